// File: rtl/uart_program_loader.sv
// Boot-time program loader: receives a framed image over 8N1 UART, writes
// little-endian 32-bit words into the ITCM and keeps the core held in reset
// until a complete image passes its XOR checksum.
module uart_program_loader #(
   parameter int unsigned CLKS_PER_BIT = 1476,
   parameter int unsigned MAX_WORDS    = 1024,
   parameter int unsigned TIMEOUT_CLKS = 17000000
) (
   input  logic        clk,
   input  logic        cpu_rst,
   input  logic        uart_rx,
   output logic        core_hold,
   output logic        itcm_we,
   output logic [11:0] itcm_addr,
   output logic [31:0] itcm_wdata,
   output logic        loading,
   output logic        error,
   output logic [10:0] word_count
);

   localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
   localparam int unsigned BIT_CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TMO_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam int unsigned WC_W      = 11;
   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned LEN_W     = 16;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   // ------------------------------------------------------------------
   // RX front end
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   logic [1:0]           rx_sync;
   logic                 rx_s;
   logic                 rx_prev;
   rx_state_t            rx_state;
   rx_state_t            rx_state_next;
   logic [BIT_CNT_W-1:0] rx_cnt;
   logic [BIT_CNT_W-1:0] rx_cnt_d;
   logic [2:0]           rx_bit;
   logic [2:0]           rx_bit_d;
   logic [7:0]           rx_byte;
   logic [7:0]           rx_byte_d;
   logic                 rx_valid;
   logic                 rx_valid_d;
   logic                 rx_ferr;
   logic                 rx_ferr_d;
   logic                 half_tick;
   logic                 full_tick;

   assign rx_s      = rx_sync[1];
   assign half_tick = (rx_cnt == BIT_CNT_W'(HALF_BIT - 1));
   assign full_tick = (rx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (!cpu_rst) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], uart_rx};
         rx_prev <= rx_s;
      end
   end

   // RX state register
   always_ff @(posedge clk) begin
      if (!cpu_rst) begin
         rx_state <= RX_IDLE;
      end else begin
         rx_state <= rx_state_next;
      end
   end

   // RX next-state logic
   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s) rx_state_next = RX_START;
         RX_START: if (half_tick) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && (rx_bit == 3'd7)) rx_state_next = RX_STOP;
         RX_STOP:  if (full_tick) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   // RX datapath: bit timing, LSB-first shift, stop-bit verdict
   always_comb begin
      rx_cnt_d   = rx_cnt;
      rx_bit_d   = rx_bit;
      rx_byte_d  = rx_byte;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
         end
         RX_START: begin
            rx_cnt_d = half_tick ? '0 : BIT_CNT_W'(rx_cnt + 1'b1);
         end
         RX_DATA: begin
            rx_cnt_d = full_tick ? '0 : BIT_CNT_W'(rx_cnt + 1'b1);
            if (full_tick) begin
               rx_byte_d = {rx_s, rx_byte[7:1]};
               rx_bit_d  = 3'(rx_bit + 3'd1);
            end
         end
         RX_STOP: begin
            rx_cnt_d = full_tick ? '0 : BIT_CNT_W'(rx_cnt + 1'b1);
            if (full_tick) begin
               rx_valid_d = rx_s;
               rx_ferr_d  = !rx_s;
            end
         end
         default: begin
            rx_cnt_d = '0;
         end
      endcase
   end

   // RX datapath registers
   always_ff @(posedge clk) begin
      if (!cpu_rst) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
         rx_byte  <= rx_byte_d;
         rx_valid <= rx_valid_d;
         rx_ferr  <= rx_ferr_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame loader
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } ld_state_t;

   ld_state_t         state;
   ld_state_t         state_next;
   logic [7:0]        len_lo;
   logic [7:0]        len_lo_d;
   logic [WC_W-1:0]   len_words;
   logic [WC_W-1:0]   len_words_d;
   logic [1:0]        byte_idx;
   logic [1:0]        byte_idx_d;
   logic [23:0]       word_asm;
   logic [23:0]       word_asm_d;
   logic [7:0]        checksum;
   logic [7:0]        checksum_d;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [TMO_W-1:0]  tmo_cnt_d;
   logic              core_hold_d;
   logic              itcm_we_d;
   logic [ADDR_W-1:0] itcm_addr_d;
   logic [DATA_W-1:0] itcm_wdata_d;
   logic              loading_d;
   logic              error_d;
   logic [WC_W-1:0]   word_count_d;
   logic              in_frame;
   logic              next_in_frame;
   logic              is_sync;
   logic              tmo_expire;
   logic              word_last;
   logic [LEN_W-1:0]  len_field;

   assign in_frame      = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                          (state == ST_DATA)   || (state == ST_CHECK);
   assign next_in_frame = (state_next == ST_LEN_LO) || (state_next == ST_LEN_HI) ||
                          (state_next == ST_DATA)   || (state_next == ST_CHECK);
   assign is_sync       = rx_valid && (rx_byte == SYNC_BYTE);
   assign tmo_expire    = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));
   assign word_last     = (WC_W'(word_count + 1'b1) == len_words);
   assign len_field     = {rx_byte, len_lo};

   // Loader state register
   always_ff @(posedge clk) begin
      if (!cpu_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Loader next-state logic; framing errors and inter-byte timeout abort any frame
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (is_sync) state_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (rx_valid) state_next = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (rx_valid) begin
               if ((len_field == '0) || (len_field > LEN_W'(MAX_WORDS))) begin
                  state_next = ST_ERROR;
               end else begin
                  state_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_valid && (byte_idx == 2'd3) && word_last) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (rx_valid) state_next = (rx_byte == checksum) ? ST_DONE : ST_ERROR;
         end
         default: state_next = ST_IDLE;
      endcase
      if (in_frame && (rx_ferr || tmo_expire)) state_next = ST_ERROR;
   end

   // Loader outputs and datapath next values
   always_comb begin
      len_lo_d     = len_lo;
      len_words_d  = len_words;
      byte_idx_d   = byte_idx;
      word_asm_d   = word_asm;
      checksum_d   = checksum;
      core_hold_d  = core_hold;
      itcm_we_d    = 1'b0;
      itcm_addr_d  = itcm_addr;
      itcm_wdata_d = itcm_wdata;
      error_d      = error;
      word_count_d = word_count;
      loading_d    = next_in_frame;
      tmo_cnt_d    = (in_frame && !rx_valid) ? TMO_W'(tmo_cnt + 1'b1) : '0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (is_sync) begin
               core_hold_d  = 1'b1;
               error_d      = 1'b0;
               word_count_d = '0;
               checksum_d   = '0;
               byte_idx_d   = '0;
            end
         end
         ST_LEN_LO: begin
            if (rx_valid) len_lo_d = rx_byte;
         end
         ST_LEN_HI: begin
            if (rx_valid) len_words_d = WC_W'(len_field);
         end
         ST_DATA: begin
            if (rx_valid) begin
               checksum_d = checksum ^ rx_byte;
               word_asm_d = {rx_byte, word_asm[23:8]};
               byte_idx_d = 2'(byte_idx + 2'd1);
               if (byte_idx == 2'd3) begin
                  itcm_we_d    = 1'b1;
                  itcm_wdata_d = {rx_byte, word_asm};
                  itcm_addr_d  = {word_count[WC_W-2:0], 2'b00};
                  word_count_d = WC_W'(word_count + 1'b1);
               end
            end
         end
         ST_CHECK: begin
            if (state_next == ST_DONE) core_hold_d = 1'b0;
         end
         default: begin
            core_hold_d = 1'b1;
         end
      endcase
      if (state_next == ST_ERROR) error_d = 1'b1;
   end

   // Loader datapath and output registers
   always_ff @(posedge clk) begin
      if (!cpu_rst) begin
         len_lo     <= '0;
         len_words  <= '0;
         byte_idx   <= '0;
         word_asm   <= '0;
         checksum   <= '0;
         tmo_cnt    <= '0;
         core_hold  <= 1'b1;
         itcm_we    <= 1'b0;
         itcm_addr  <= '0;
         itcm_wdata <= '0;
         loading    <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         len_lo     <= len_lo_d;
         len_words  <= len_words_d;
         byte_idx   <= byte_idx_d;
         word_asm   <= word_asm_d;
         checksum   <= checksum_d;
         tmo_cnt    <= tmo_cnt_d;
         core_hold  <= core_hold_d;
         itcm_we    <= itcm_we_d;
         itcm_addr  <= itcm_addr_d;
         itcm_wdata <= itcm_wdata_d;
         loading    <= loading_d;
         error      <= error_d;
         word_count <= word_count_d;
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serialises frames onto uart_rx and compares
// ITCM writes and status against a frame-level expectation model.
module tb_uart_program_loader;

   localparam int unsigned CPB  = 16;
   localparam int unsigned MAXW = 1024;
   localparam int unsigned TMO  = 2000;

   logic        clk = 1'b0;
   logic        cpu_rst = 1'b0;
   logic        uart_rx = 1'b1;
   logic        core_hold;
   logic        itcm_we;
   logic [11:0] itcm_addr;
   logic [31:0] itcm_wdata;
   logic        loading;
   logic        error;
   logic [10:0] word_count;

   int total = 0;
   int bad   = 0;

   logic [43:0] obs_q[$];
   logic [43:0] exp_q[$];
   logic [31:0] frame_words [0:15];

   uart_program_loader #(
      .CLKS_PER_BIT(CPB),
      .MAX_WORDS   (MAXW),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk       (clk),
      .cpu_rst   (cpu_rst),
      .uart_rx   (uart_rx),
      .core_hold (core_hold),
      .itcm_we   (itcm_we),
      .itcm_addr (itcm_addr),
      .itcm_wdata(itcm_wdata),
      .loading   (loading),
      .error     (error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Capture every ITCM write strobe
   always @(negedge clk) begin
      if (itcm_we === 1'b1) obs_q.push_back({itcm_addr, itcm_wdata});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 character; hold_mid samples core_hold early in the stop bit
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, output logic hold_mid);
      uart_rx = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_cycles(CPB);
      end
      uart_rx = stop_bit;
      wait_cycles(4);
      hold_mid = core_hold;
      wait_cycles(CPB - 4);
      uart_rx = 1'b1;
      wait_cycles(2);
   endtask

   task automatic send(input logic [7:0] b);
      logic hm;
      send_byte(b, 1'b1, hm);
   endtask

   task automatic check_status(input string tag, input logic hold, input logic err,
                               input int wc, input logic load);
      check({tag, "_hold"}, core_hold, hold);
      check({tag, "_error"}, error, err);
      check({tag, "_wcount"}, word_count, 64'(wc));
      check({tag, "_loading"}, loading, load);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_write%0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   // Sends a whole frame from frame_words; expectations follow the frame rules
   task automatic run_frame(input string tag, input int n_field, input int n, input bit corrupt);
      logic [15:0] nf;
      logic [7:0]  chk;
      logic [7:0]  b;
      logic [31:0] w;
      logic        hm;
      nf  = 16'(n_field);
      chk = 8'h00;
      send(8'hA5);
      check({tag, "_sync_loading"}, loading, 1'b1);
      send(nf[7:0]);
      send(nf[15:8]);
      if (n_field == 0 || n_field > int'(MAXW)) begin
         wait_cycles(4);
         check_status({tag, "_badlen"}, 1'b1, 1'b1, 0, 1'b0);
         compare_writes({tag, "_badlen"});
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = frame_words[i];
         for (int k = 0; k < 4; k++) begin
            b   = w[8*k +: 8];
            chk = chk ^ b;
            send(b);
         end
         exp_q.push_back({12'(i * 4), w});
      end
      if (corrupt) chk = chk ^ 8'h01;
      send_byte(chk, 1'b1, hm);
      check({tag, "_hold_before_chk"}, hm, 1'b1);
      if (corrupt) check_status(tag, 1'b1, 1'b1, n, 1'b0);
      else         check_status(tag, 1'b0, 1'b0, n, 1'b0);
      compare_writes(tag);
   endtask

   initial begin
      // Reset and idle line
      wait_cycles(5);
      check_status("reset", 1'b1, 1'b0, 0, 1'b0);
      check("reset_we", itcm_we, 1'b0);
      check("reset_addr", itcm_addr, 12'h000);
      check("reset_wdata", itcm_wdata, 32'h0);
      cpu_rst = 1'b1;
      wait_cycles(1000);
      send(8'h3C);
      send(8'h00);
      check_status("idle", 1'b1, 1'b0, 0, 1'b0);
      compare_writes("idle");

      // Known-good two-word frame, then bad checksum, then resend
      frame_words[0] = 32'h0000_0013;
      frame_words[1] = 32'h0010_0093;
      run_frame("good", 2, 2, 1'b0);
      run_frame("badchk", 2, 2, 1'b1);
      run_frame("resend", 2, 2, 1'b0);

      // Length out of range
      run_frame("len1025", 16'h0401, 0, 1'b0);
      run_frame("len0", 0, 0, 1'b0);

      // Inter-byte timeout after the 5th payload byte
      frame_words[0] = 32'hDEAD_BEEF;
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); send(8'h11);
      exp_q.push_back({12'h000, 32'hDEAD_BEEF});
      wait_cycles(TMO - 100);
      check("tmo_early_error", error, 1'b0);
      check("tmo_early_loading", loading, 1'b1);
      wait_cycles(200);
      check_status("tmo", 1'b1, 1'b1, 1, 1'b0);
      compare_writes("tmo");

      // Framing error mid-frame
      begin
         logic hm;
         send(8'hA5); send(8'h02); send(8'h00);
         send(8'h01); send(8'h02);
         send_byte(8'h33, 1'b0, hm);
         wait_cycles(4);
         check_status("ferr", 1'b1, 1'b1, 0, 1'b0);
         compare_writes("ferr");
         wait_cycles(20);
      end

      // Reset in the middle of a frame, then a fresh one-word frame
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h44); send(8'h55); send(8'h66);
      cpu_rst = 1'b0;
      wait_cycles(1);
      cpu_rst = 1'b1;
      wait_cycles(1);
      check_status("midrst", 1'b1, 1'b0, 0, 1'b0);
      check("midrst_addr", itcm_addr, 12'h000);
      check("midrst_wdata", itcm_wdata, 32'h0);
      wait_cycles(30);
      frame_words[0] = 32'h1234_5678;
      run_frame("after_rst", 1, 1, 1'b0);

      // Randomised frames; first one carries sync bytes as payload
      for (int f = 0; f < 5; f++) begin
         int n;
         bit corrupt;
         n = $urandom_range(1, 4);
         corrupt = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < n; i++) frame_words[i] = $urandom();
         if (f == 0) frame_words[0] = 32'hA5A5_00A5;
         run_frame($sformatf("rand%0d", f), n, n, corrupt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
